// File: rtl/piso_pkg.sv
// Shared FSM encodings and sizing helper for the parallel-in/serial-out serializer.
package piso_pkg;

  localparam logic IDLE  = 1'b0;
  localparam logic SHIFT = 1'b1;

  typedef enum logic {
    StIdle  = IDLE,
    StShift = SHIFT
  } state_e;

  // Bit-counter width for a word of the given size; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Bit-position counter: cleared when a word is accepted, advanced once per emitted bit.
module bit_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a load handshake and gapless back-to-back words.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int unsigned      CNT_W      = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PENULT_CNT = CNT_W'(WIDTH - 2);

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic             r_s_out, w_s_out_nxt;
  logic             r_s_valid, w_s_valid_nxt;
  logic             r_frame_start, w_frame_start_nxt;
  logic             r_done, w_done_nxt;

  logic [CNT_W-1:0] w_count;
  logic             w_last;
  logic             w_load_ready;
  logic             w_accept;
  logic             w_cnt_en;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // The counter holds the index of the bit currently on s_out.
  assign w_last       = (r_state == StShift) && (w_count == LAST_CNT);
  assign w_load_ready = !rst && ((r_state == StIdle) || w_last);
  assign w_accept     = load_valid && w_load_ready;
  assign w_cnt_en     = (r_state == StShift) && !w_last;

  bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_accept),
    .enable (w_cnt_en),
    .count  (w_count)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_shift_nxt       = r_shift;
    w_s_out_nxt       = r_s_out;
    w_s_valid_nxt     = r_s_valid;
    w_frame_start_nxt = r_frame_start;
    w_done_nxt        = r_done;
    if (w_accept) begin
      w_state_nxt       = StShift;
      w_s_out_nxt       = head_bit(d_in);
      w_shift_nxt       = drop_head(d_in);
      w_s_valid_nxt     = 1'b1;
      w_frame_start_nxt = 1'b1;
      w_done_nxt        = 1'b0;
    end else if (r_state == StShift) begin
      if (w_last) begin
        w_state_nxt       = StIdle;
        w_s_out_nxt       = 1'b0;
        w_s_valid_nxt     = 1'b0;
        w_frame_start_nxt = 1'b0;
        w_done_nxt        = 1'b0;
      end else begin
        w_s_out_nxt       = head_bit(r_shift);
        w_shift_nxt       = drop_head(r_shift);
        w_s_valid_nxt     = 1'b1;
        w_frame_start_nxt = 1'b0;
        w_done_nxt        = (w_count == PENULT_CNT);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_shift       <= '0;
      r_s_out       <= 1'b0;
      r_s_valid     <= 1'b0;
      r_frame_start <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_shift       <= w_shift_nxt;
      r_s_out       <= w_s_out_nxt;
      r_s_valid     <= w_s_valid_nxt;
      r_frame_start <= w_frame_start_nxt;
      r_done        <= w_done_nxt;
    end
  end

  assign load_ready  = w_load_ready;
  assign s_out       = r_s_out;
  assign s_valid     = r_s_valid;
  assign frame_start = r_frame_start;
  assign done        = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances against a queue-based bit model.
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] d_in = '0;
  logic         load_valid = 1'b0;

  logic m_ready, m_sout, m_svalid, m_fs, m_done;
  logic l_ready, l_sout, l_svalid, l_fs, l_done;

  always #10 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .d_in        (d_in),
    .load_valid  (load_valid),
    .load_ready  (m_ready),
    .s_out       (m_sout),
    .s_valid     (m_svalid),
    .frame_start (m_fs),
    .done        (m_done)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk         (clk),
    .rst         (rst),
    .d_in        (d_in),
    .load_valid  (load_valid),
    .load_ready  (l_ready),
    .s_out       (l_sout),
    .s_valid     (l_svalid),
    .frame_start (l_fs),
    .done        (l_done)
  );

  typedef struct packed {
    logic v;
    logic fs;
    logic dn;
    logic b;
  } item_t;

  int    tests = 0;
  int    fails = 0;
  item_t pend_m[$];
  item_t pend_l[$];
  item_t cur_m = '0;
  item_t cur_l = '0;
  logic [15:0] cap_m, cap_l;
  int          nvalid;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_capture();
    cap_m  = '0;
    cap_l  = '0;
    nvalid = 0;
  endtask

  // Ready whenever no bits of the current word remain after the one on the wire.
  function automatic bit model_ready();
    return (rst === 1'b0) && (pend_m.size() == 0);
  endfunction

  task automatic model_load(input logic [W-1:0] w);
    pend_m.delete();
    pend_l.delete();
    for (int i = 0; i < W; i++) begin
      pend_m.push_back('{v: 1'b1, fs: (i == 0), dn: (i == W - 1), b: w[W-1-i]});
      pend_l.push_back('{v: 1'b1, fs: (i == 0), dn: (i == W - 1), b: w[i]});
    end
  endtask

  task automatic model_reset();
    pend_m.delete();
    pend_l.delete();
    cur_m = '0;
    cur_l = '0;
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_msb_out"}, {m_svalid, m_fs, m_done, m_sout}, cur_m);
    chk({tag, "_lsb_out"}, {l_svalid, l_fs, l_done, l_sout}, cur_l);
    if (m_svalid === 1'b1) begin
      cap_m = {cap_m[14:0], m_sout};
      nvalid++;
    end
    if (l_svalid === 1'b1) cap_l = {cap_l[14:0], l_sout};
  endtask

  // Called at a falling edge: drive, check ready, clock, check outputs at the next falling edge.
  task automatic cycle(input logic v, input logic [W-1:0] d, input string tag);
    bit rdy;
    bit acc;
    load_valid = v;
    d_in       = d;
    #1;
    rdy = model_ready();
    chk({tag, "_msb_ready"}, 16'(m_ready), 16'(rdy));
    chk({tag, "_lsb_ready"}, 16'(l_ready), 16'(rdy));
    acc = rdy && (v === 1'b1);
    @(posedge clk);
    if (acc) model_load(d);
    if (pend_m.size() > 0) begin
      cur_m = pend_m.pop_front();
      cur_l = pend_l.pop_front();
    end else begin
      cur_m = '0;
      cur_l = '0;
    end
    @(negedge clk);
    check_out(tag);
  endtask

  // Asserts rst away from the clock edge, checks the immediate effect, holds for two edges.
  task automatic async_reset(input string tag);
    #5 rst = 1'b1;
    model_reset();
    #1;
    check_out({tag, "_imm"});
    chk({tag, "_imm_ready"}, 16'({m_ready, l_ready}), 16'd0);
    repeat (2) begin
      @(negedge clk);
      check_out({tag, "_hold"});
      chk({tag, "_hold_ready"}, 16'({m_ready, l_ready}), 16'd0);
    end
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] tog;
    clear_capture();

    async_reset("reset");
    cycle(1'b0, 4'b0000, "first_idle");

    // Single word.
    clear_capture();
    cycle(1'b1, 4'b1101, "single");
    repeat (4) cycle(1'b0, 4'b0000, "single");
    chk("single_bits", cap_m, 16'b1101);
    chk("single_count", 16'(nvalid), 16'd4);

    // Back-to-back words with load_valid held.
    clear_capture();
    cycle(1'b1, 4'b0010, "b2b");
    repeat (4) cycle(1'b1, 4'b1111, "b2b");
    repeat (4) cycle(1'b0, 4'b0000, "b2b");
    chk("b2b_bits", cap_m, 16'b0010_1111);
    chk("b2b_count", 16'(nvalid), 16'd8);
    chk("lsb_first_bits", cap_l, 16'b0100_1111);

    // Reset in the middle of a word, then a fresh word.
    clear_capture();
    cycle(1'b1, 4'b1111, "midrst");
    cycle(1'b0, 4'b0000, "midrst");
    async_reset("midrst_rst");
    chk("midrst_partial", cap_m, 16'b11);
    clear_capture();
    cycle(1'b1, 4'b0001, "after_rst");
    repeat (4) cycle(1'b0, 4'b0000, "after_rst");
    chk("after_rst_bits", cap_m, 16'b0001);
    chk("after_rst_lsb", cap_l, 16'b1000);

    // d_in toggling (and X) while the block is busy must not disturb the word.
    clear_capture();
    cycle(1'b1, 4'b1010, "stable");
    tog = 4'b0101;
    cycle(1'bx, 4'bxxxx, "stable");
    cycle(1'b1, tog, "stable");
    tog = ~tog;
    cycle(1'b0, tog, "stable");
    cycle(1'b0, 4'b0000, "stable");
    chk("stable_bits", cap_m, 16'b1010);
    chk("stable_lsb", cap_l, 16'b0101);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        async_reset("rnd_rst");
      end else begin
        cycle(($urandom_range(0, 3) != 0), W'($urandom), "rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
